// File: rtl/pbp_gen2.sv
// pbp_gen2: hashed perceptron branch-direction predictor with saturating weights,
// a two-stage read-modify-write trainer and a post-reset table clear. Macro PBP_SPEC_GHR_EN selects the speculative GHR.
module pbp_gen2 #(
  parameter int unsigned W_BITS   = 8,
  parameter int unsigned HIST_LEN = 12,
  parameter int unsigned SET_BITS = 5,
  parameter int unsigned THETA    = 37,
  localparam int unsigned Y_BITS  = W_BITS + $clog2(HIST_LEN + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  output logic                     ready,
  input  logic [31:0]              if_pc,
  input  logic                     if_is_br,
  output logic                     if_bp_br_en,
  output logic signed [Y_BITS-1:0] if_y_out,
  output logic [HIST_LEN-1:0]      if_ghr,
  input  logic                     exmem_is_br,
  input  logic [31:0]              exmem_pc,
  input  logic                     exmem_br_en,
  input  logic                     exmem_bp_br_en,
  input  logic signed [Y_BITS-1:0] exmem_y_out,
  input  logic [HIST_LEN-1:0]      exmem_ghr
);

  localparam int unsigned ROWS = 2 ** SET_BITS;
  localparam int unsigned N_W  = HIST_LEN + 1;
  localparam logic [W_BITS-1:0] W_MAX   = {1'b0, {(W_BITS-1){1'b1}}};
  localparam logic [W_BITS-1:0] W_MIN   = {1'b1, {(W_BITS-1){1'b0}}};
  localparam logic [Y_BITS-1:0] THETA_Y = Y_BITS'(THETA);

  // Element 0 is the bias weight; element i+1 pairs with history bit i.
  typedef logic [N_W-1:0][W_BITS-1:0] row_t;
  typedef enum logic {ST_INIT, ST_RUN} state_t;

  function automatic logic [Y_BITS-1:0] sext(input logic [W_BITS-1:0] v);
    return {{(Y_BITS-W_BITS){v[W_BITS-1]}}, v};
  endfunction

  function automatic logic [W_BITS-1:0] sat_step(input logic [W_BITS-1:0] v, input logic up);
    logic [W_BITS-1:0] r;
    r = v;
    if (up && (v != W_MAX))       r = v + W_BITS'(1);
    else if (!up && (v != W_MIN)) r = v - W_BITS'(1);
    return r;
  endfunction

  state_t                r_state;
  state_t                w_state_nxt;
  logic [SET_BITS-1:0]   r_init_cnt;
  logic [SET_BITS-1:0]   w_init_cnt_nxt;
  logic                  w_tbl_clr;
  logic                  w_run;

  row_t                  r_tbl [ROWS];

  logic [SET_BITS-1:0]   w_pred_idx;
  row_t                  w_pred_row;
  logic [Y_BITS-1:0]     w_y_sum;

  logic [SET_BITS-1:0]   w_trn_idx;
  logic                  w_mispred;
  logic [Y_BITS-1:0]     w_y_abs;
  logic                  w_train;
  row_t                  w_t1_row;

  logic                  r_t2_vld;
  logic [SET_BITS-1:0]   r_t2_idx;
  logic [HIST_LEN-1:0]   r_t2_ghr;
  logic                  r_t2_taken;
  row_t                  r_t2_row;
  row_t                  w_upd_row;

  logic [HIST_LEN-1:0]   r_cmt_ghr;
  logic                  w_addr_unused;
  logic                  w_unused_ok;

  // Init sequencer: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_INIT;
      r_init_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_cnt <= w_init_cnt_nxt;
    end
  end

  // Init sequencer: clears one row per cycle, then hands over to RUN
  always_comb begin
    w_state_nxt    = r_state;
    w_init_cnt_nxt = r_init_cnt;
    w_tbl_clr      = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_tbl_clr      = 1'b1;
        w_init_cnt_nxt = r_init_cnt + SET_BITS'(1);
        if (&r_init_cnt) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  assign w_run = (r_state == ST_RUN);
  assign ready = w_run;

  // Prediction: combinational dot product over the hashed row
  assign w_pred_idx = if_pc[SET_BITS+1:2] ^ if_ghr[SET_BITS-1:0];

  always_comb begin
    w_pred_row = r_tbl[w_pred_idx];
    w_y_sum    = sext(w_pred_row[0]);
    for (int i = 0; i < HIST_LEN; i++) begin
      if (if_ghr[i]) w_y_sum = w_y_sum + sext(w_pred_row[i+1]);
      else           w_y_sum = w_y_sum - sext(w_pred_row[i+1]);
    end
  end

  assign if_y_out    = ready ? w_y_sum : '0;
  assign if_bp_br_en = ready && !w_y_sum[Y_BITS-1] && (w_y_sum != '0);

  // Train decision; the magnitude of the most negative y is correct as an unsigned value
  assign w_trn_idx = exmem_pc[SET_BITS+1:2] ^ exmem_ghr[SET_BITS-1:0];
  assign w_mispred = exmem_bp_br_en ^ exmem_br_en;
  assign w_y_abs   = exmem_y_out[Y_BITS-1] ? (~exmem_y_out + Y_BITS'(1)) : exmem_y_out;
  assign w_train   = w_run && load && exmem_is_br && (w_mispred || (w_y_abs <= THETA_Y));

  // T2 update of the latched row
  always_comb begin
    w_upd_row    = r_t2_row;
    w_upd_row[0] = sat_step(r_t2_row[0], r_t2_taken);
    for (int i = 0; i < HIST_LEN; i++) begin
      w_upd_row[i+1] = sat_step(r_t2_row[i+1], r_t2_taken == r_t2_ghr[i]);
    end
  end

  // T1 read with forwarding so back-to-back trains to one row accumulate
  assign w_t1_row = (r_t2_vld && (r_t2_idx == w_trn_idx)) ? w_upd_row : r_tbl[w_trn_idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_t2_vld   <= 1'b0;
      r_t2_idx   <= '0;
      r_t2_ghr   <= '0;
      r_t2_taken <= 1'b0;
      r_t2_row   <= '0;
    end else begin
      r_t2_vld <= w_train;
      if (w_train) begin
        r_t2_idx   <= w_trn_idx;
        r_t2_ghr   <= exmem_ghr;
        r_t2_taken <= exmem_br_en;
        r_t2_row   <= w_t1_row;
      end
    end
  end

  // Weight table: no reset, contents owned by the init sequencer
  always_ff @(posedge clk) begin
    if (w_tbl_clr)     r_tbl[r_init_cnt] <= '0;
    else if (r_t2_vld) r_tbl[r_t2_idx]   <= w_upd_row;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                              r_cmt_ghr <= '0;
    else if (w_run && load && exmem_is_br) r_cmt_ghr <= {r_cmt_ghr[HIST_LEN-2:0], exmem_br_en};
  end

  assign w_addr_unused = ^{if_pc[31:SET_BITS+2], if_pc[1:0], exmem_pc[31:SET_BITS+2], exmem_pc[1:0]};

`ifdef PBP_SPEC_GHR_EN
  logic [HIST_LEN-1:0] r_spec_ghr;

  // Repair beats the IF shift: the IF instruction is being flushed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_spec_ghr <= '0;
    end else if (w_run && load && exmem_is_br && w_mispred) begin
      r_spec_ghr <= {exmem_ghr[HIST_LEN-2:0], exmem_br_en};
    end else if (w_run && load && if_is_br) begin
      r_spec_ghr <= {r_spec_ghr[HIST_LEN-2:0], if_bp_br_en};
    end
  end

  assign if_ghr      = r_spec_ghr;
  assign w_unused_ok = ^{r_cmt_ghr, w_addr_unused};
`else
  assign if_ghr      = r_cmt_ghr;
  assign w_unused_ok = ^{if_is_br, w_addr_unused};
`endif

endmodule

// File: doc/pbp_gen2.md
Name: pbp_gen2

Overview:
- Second-generation perceptron branch direction predictor for the IF/EX-MEM pipeline; branch targets stay with the separate BTB.
- Generalised in weight width, history length, table depth and training threshold.
- Adds a hashed index, saturating weights, a speculative GHR with mispredict repair, a pipelined read-modify-write trainer with forwarding, and a post-reset table-clear sequencer.

Parameters:
W_BITS, 8, signed weight width
HIST_LEN, 12, global history length; must be >= SET_BITS
SET_BITS, 5, log2 of perceptron rows
THETA, 37, training threshold on |y|
Y_BITS, W_BITS+$clog2(HIST_LEN+1), derived dot-product width (localparam)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
load  in  1  pipeline advance; all state updates are gated by it except init
ready  out  1  table initialised; predictor live
if_pc  in  32  fetch PC
if_is_br  in  1  IF instruction is a conditional branch
if_bp_br_en  out  1  predicted taken
if_y_out  out  Y_BITS  signed perceptron output
if_ghr  out  HIST_LEN  history snapshot used for this prediction; carried down the pipe
exmem_is_br  in  1  EX/MEM instruction is a conditional branch
exmem_pc  in  32  EX/MEM PC
exmem_br_en  in  1  resolved outcome
exmem_bp_br_en  in  1  prediction made in IF
exmem_y_out  in  Y_BITS  y carried from IF
exmem_ghr  in  HIST_LEN  snapshot carried from IF

Behaviour:
- Reset (rst=0, async): FSM=INIT, init counter=0, ready=0, GHRs=0, trainer stage empty. if_bp_br_en and if_y_out are 0 whenever ready=0.
- INIT: writes row [counter] to all-zero, one row per cycle, independent of load. After row 2^SET_BITS-1, go to RUN; ready=1 from the next cycle. Branch updates are ignored in INIT. rst asserted mid-INIT or mid-RUN restarts INIT from row 0.
- Index: idx = pc[SET_BITS+1:2] ^ ghr[SET_BITS-1:0].
  - Predict: if_pc with if_ghr.
  - Train: exmem_pc with exmem_ghr.
- Predict (combinational read):
  - y = w_bias + sum over i of (h[i] ? w[i] : -w[i]), with every term sign-extended to Y_BITS; no truncation.
  - if_bp_br_en = (y > 0); y = 0 predicts not-taken.
  - GHR bit 0 is the newest.
- Train condition: RUN && load && exmem_is_br && ((exmem_bp_br_en != exmem_br_en) || |exmem_y_out| <= THETA).
- Trainer pipeline:
  - T1: latch idx, exmem_ghr and outcome; read the row.
  - T2 (next cycle): write the row, regardless of load.
  - t = +1 if outcome taken, else -1.
  - w_bias += t; w[i] += (outcome == h[i]) ? +1 : -1.
  - Weights saturate at [-2^(W_BITS-1), 2^(W_BITS-1)-1].
- Forwarding: if T1 idx equals the T2 idx being written, T1 uses the T2 result. Back-to-back trains to one row therefore accumulate.
- Read/write ordering: a prediction read of the row being written by T2 in the same cycle sees the old weights.
- Speculative GHR (spec_ghr):
  - On RUN && load && if_is_br: spec_ghr <= {spec_ghr[HIST_LEN-2:0], if_bp_br_en}.
  - On RUN && load && exmem_is_br && mispredict: spec_ghr <= {exmem_ghr[HIST_LEN-2:0], exmem_br_en}.
  - When both occur in one cycle, the repair wins because the IF instruction is flushed.
- Commit GHR (cmt_ghr): shifts exmem_br_en on RUN && load && exmem_is_br.
- if_ghr = spec_ghr (see Optional Feature).

Optional Feature:
- Macro PBP_SPEC_GHR_EN.
- Defined: speculative GHR and mispredict repair exactly as above; if_ghr = spec_ghr.
- Undefined: spec_ghr and the repair logic are removed; if_ghr = cmt_ghr.
- Training always uses exmem_ghr in both builds.

Test Plan:
- Reset/init: release rst with SET_BITS=5 -> ready=0 for exactly 32 cycles, then 1. Any if_pc during INIT -> if_y_out=0, if_bp_br_en=0.
- Threshold: exmem_pc=0x100, exmem_ghr=0, taken, mispredicted, 3 trains with exmem_y_out = 0, 13, 26 -> row y = 13, 26, 39 (bias=3, w[i]=-3). A fourth correct prediction with y=39 -> no write.
- Saturation: W_BITS=4; 10 taken mispredicts with ghr=0 -> bias=+7, all w[i]=-8; predicted y=+103, if_bp_br_en=1.
- Forwarding: two trains to the same row on consecutive cycles, taken, ghr=0 -> bias=+2, not +1.
- Repair priority (PBP_SPEC_GHR_EN): spec_ghr=0x005; same cycle if_is_br=1 and exmem mispredict with exmem_ghr=0x00F, br_en=1 -> spec_ghr=0x01F.
- Stall: exmem_is_br=1 with load=0 for 5 cycles -> weights, spec_ghr and cmt_ghr unchanged.
